div_issue_ctrl: RTL
===================

// Module: div_issue_ctrl
// PURPOSE
//  Requester side of the iterative divider handshake (valid/sign/x/y -> result/rem/finish).
//  Sits between the EXU and the divider and decodes RV64M DIV/DIVU/REM/REMU and the W forms.
//  Prepares the operands, resolves divide-by-zero and signed overflow without using the divider,
//  issues one request at a time and returns a single XLEN result through a valid/ready handshake.
// PARAMETERS
//  XLEN  64  datapath width; the divider is XLEN wide
// PORTS
//  clk          in   1     single clock; all logic on posedge
//  rst_n        in   1     synchronous reset, active-low
//  in_valid     in   1     EXU request valid
//  in_ready     out  1     controller can accept a request
//  in_op        in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  in_word      in   1     1 = W form (32-bit operation, result sign-extended)
//  in_a, in_b   in   XLEN  dividend, divisor (rs1, rs2)
//  flush        in   1     kill the in-flight operation
//  out_valid    out  1     result valid
//  out_ready    in   1     EXU accepts the result
//  out_data     out  XLEN  quotient or remainder, selected by op
//  div_valid    out  1     request pulse to the divider
//  div_sign     out  1     signed-operation select to the divider
//  div_x,div_y  out  XLEN  operands to the divider
//  div_result   in   XLEN  quotient from the divider
//  div_rem      in   XLEN  remainder from the divider
//  div_finish   in   1     one-cycle done pulse from the divider
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE. All outputs are 0 except in_ready=1.
//   The divider shares rst_n, so after reset no divider operation is pending.
//  States: IDLE, ISSUE, WAIT, RESP, DRAIN (one-hot).
//  IDLE: in_ready=1. Accept on in_valid. Operands are extended in the same cycle:
//   W form: the low 32 bits of a and b are sign-extended (DIV/REM) or zero-extended (DIVU/REMU).
//   Non-W form: a and b are used unchanged.
//   Special case (divisor==0, or signed overflow MIN/-1 at the operation width):
//    the result is registered directly and the next state is RESP. No divider request is made.
//   Otherwise: div_x, div_y and div_sign are registered and the next state is ISSUE.
//  ISSUE: div_valid=1 for exactly one cycle, then WAIT.
//  WAIT: div_x, div_y and div_sign stay stable. The divider reads the operand signs
//   combinationally until it finishes. On div_finish, capture div_result or div_rem and go to RESP.
//  RESP: out_valid=1 and out_data is held until out_ready; then IDLE.
//   out_ready is a don't-care when out_valid=0. There is no out->in bypass:
//   the next request is accepted in the cycle after the RESP handshake.
//  Special-case results, computed at the operation width:
//   divisor 0:       quotient = all ones; remainder = dividend.
//   overflow MIN/-1: quotient = MIN;      remainder = 0.
//  W form: out_data = sign-extend(result[31:0]). This also applies to DIVUW and REMUW.
//  Latency from accept to out_valid:
//   special case: 1 cycle.
//   normal:       2 + divider latency.
//  Flush:
//   IDLE:         no effect. A same-cycle in_valid is not accepted.
//   ISSUE, WAIT:  go to DRAIN. div_valid is suppressed if not yet sent.
//                 If already sent, DRAIN waits for div_finish; the result is discarded; then IDLE.
//   RESP:         drop the result, go to IDLE.
//   Flush has priority over div_finish and over out_ready in the same cycle.
//   ISSUE flushed before div_valid is sent goes to IDLE, not DRAIN.
//  DRAIN: in_ready=0. The divider has no abort, so the controller never re-issues before finish.
//  div_finish seen outside WAIT/DRAIN: ignored. It is flagged by an assertion in the bench.
// STRUCTURE
//  div_pkg: op encodings (DIV_OP_*), state one-hot constants, XLEN default.
//  Sub-module div_operand_prep (combinational): width extension,
//   zero/overflow detection and special-result generation.
//  The FSM and the operand/result registers live in this top module.
// TESTING
//  1 DIV a=-7 b=2 -> out_data=-3 (0xFFFF_FFFF_FFFF_FFFD); div_valid pulses once; one result.
//  2 REM a=-7 b=2 -> out_data=-1; REMU a=7 b=0 -> out_data=7, out_valid 1 cycle after accept,
//    div_valid never asserted.
//  3 DIV a=0x8000_0000_0000_0000 b=-1 -> out_data=0x8000_0000_0000_0000.
//    DIVW a=0x8000_0000 b=0xFFFF_FFFF -> out_data=0xFFFF_FFFF_8000_0000.
//  4 DIVUW a=0x1_FFFF_FFF9 b=2 -> div_x=0xFFFF_FFF9, out_data=0x0000_0000_7FFF_FFFC.
//    DIVU a=5 b=0 -> out_data=all ones.
//  5 Flush 3 cycles into WAIT; in_valid held high -> in_ready=0 until div_finish;
//    no out_valid; the next request completes correctly.
//  6 out_ready low 5 cycles in RESP -> out_valid/out_data stable.
//    rst_n low mid-WAIT -> in_ready=1, div_valid=0 the next cycle.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller.
//  - XLEN_DEFAULT: default datapath width (the divider is XLEN wide)
//  - DIV_OP_*:     2-bit operation encodings driven by the EXU on in_op
//  - state_e:      one-hot controller states
package div_issue_ctrl_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ISSUE = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_RESP  = 5'b01000,
    ST_DRAIN = 5'b10000
  } state_e;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Handshake bus between the issue controller and the iterative divider.
//  master (controller): div_valid, div_sign, div_x, div_y out; div_result, div_rem, div_finish in
//  slave  (divider):    the mirror image
//  div_valid  request pulse          div_sign  signed-operation select
//  div_x/y    operands (held stable until div_finish)
//  div_result quotient, div_rem remainder, div_finish one-cycle done pulse
interface div_issue_ctrl_if import div_issue_ctrl_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            div_valid;
  logic            div_sign;
  logic [XLEN-1:0] div_x;
  logic [XLEN-1:0] div_y;
  logic [XLEN-1:0] div_result;
  logic [XLEN-1:0] div_rem;
  logic            div_finish;

  modport master (
    output div_valid, div_sign, div_x, div_y,
    input  div_result, div_rem, div_finish
  );

  modport slave (
    input  div_valid, div_sign, div_x, div_y,
    output div_result, div_rem, div_finish
  );

endinterface

// File: rtl/div_issue_ctrl_operand_prep.sv
// Combinational operand preparation for the divider issue controller.
//  op, word, a, b    in   raw request from the EXU
//  x, y              out  operands extended to XLEN as the divider expects them
//  sign              out  signed operation (DIV/REM)
//  rem_sel           out  remainder requested (REM/REMU)
//  special           out  divide-by-zero or signed overflow; no divider request needed
//  special_result    out  final (already W-form sign-extended) result for the special case
module div_issue_ctrl_operand_prep import div_issue_ctrl_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] x,
  output logic [XLEN-1:0] y,
  output logic            sign,
  output logic            rem_sel,
  output logic            special,
  output logic [XLEN-1:0] special_result
);

  logic [XLEN-1:0] min_ext;
  logic [XLEN-1:0] raw;
  logic            div_zero;
  logic            overflow;

  // Extend W-form operands, then detect the two cases the divider must not see.
  // The most negative value is compared in its extended form, so for W the
  // pattern is 0xFFFF_FFFF_8000_0000 (x has already been sign-extended).
  always_comb begin
    sign    = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    rem_sel = (op == DIV_OP_REM) || (op == DIV_OP_REMU);

    if (word) begin
      x = sign ? {{(XLEN-32){a[31]}}, a[31:0]} : {{(XLEN-32){1'b0}}, a[31:0]};
      y = sign ? {{(XLEN-32){b[31]}}, b[31:0]} : {{(XLEN-32){1'b0}}, b[31:0]};
      min_ext = {{(XLEN-31){1'b1}}, {31{1'b0}}};
    end else begin
      x = a;
      y = b;
      min_ext = {1'b1, {(XLEN-1){1'b0}}};
    end

    div_zero = (y == '0);
    overflow = sign && (x == min_ext) && (y == '1);
    special  = div_zero || overflow;

    if (div_zero) begin
      raw = rem_sel ? x : '1;
    end else begin
      raw = rem_sel ? '0 : min_ext;
    end

    // Unsigned W forms also return a sign-extended 32-bit value.
    special_result = word ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Requester side of the iterative divider handshake (RV64M DIV/DIVU/REM/REMU and W forms).
//  clk, rst_n                 clock, synchronous active-low reset
//  in_valid/in_ready          EXU request handshake; in_op, in_word, in_a, in_b request fields
//  flush                      kill the in-flight operation
//  out_valid/out_ready        result handshake; out_data quotient or remainder
//  div                        divider bus (master side)
module div_issue_ctrl import div_issue_ctrl_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  div_issue_ctrl_if.master div
);

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            div_valid_q, div_valid_d;
  logic            div_sign_q, div_sign_d;
  logic [XLEN-1:0] div_x_q, div_x_d;
  logic [XLEN-1:0] div_y_q, div_y_d;
  logic            rem_q, rem_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] div_sel;

  logic [XLEN-1:0] prep_x;
  logic [XLEN-1:0] prep_y;
  logic            prep_sign;
  logic            prep_rem;
  logic            prep_special;
  logic [XLEN-1:0] prep_special_result;

  div_issue_ctrl_operand_prep #(.XLEN(XLEN)) u_prep (
    .op             (in_op),
    .word           (in_word),
    .a              (in_a),
    .b              (in_b),
    .x              (prep_x),
    .y              (prep_y),
    .sign           (prep_sign),
    .rem_sel        (prep_rem),
    .special        (prep_special),
    .special_result (prep_special_result)
  );

  // Next-state logic. Flush wins over div_finish and out_ready. A flush in the
  // same cycle as div_finish goes straight to IDLE, since the divider is
  // already done and DRAIN would wait for a finish that never comes.
  // Handshake outputs are derived from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    div_sign_d = div_sign_q;
    div_x_d    = div_x_q;
    div_y_d    = div_y_q;
    rem_d      = rem_q;
    word_d     = word_q;
    result_d   = result_q;
    div_sel    = rem_q ? div.div_rem : div.div_result;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          rem_d  = prep_rem;
          word_d = in_word;
          if (prep_special) begin
            result_d = prep_special_result;
            state_d  = ST_RESP;
          end else begin
            div_x_d    = prep_x;
            div_y_d    = prep_y;
            div_sign_d = prep_sign;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = flush ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (flush) begin
          state_d = div.div_finish ? ST_IDLE : ST_DRAIN;
        end else if (div.div_finish) begin
          result_d = word_q ? {{(XLEN-32){div_sel[31]}}, div_sel[31:0]} : div_sel;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush || out_ready) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (div.div_finish) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_RESP);
    div_valid_d = (state_d == ST_ISSUE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_valid_q <= 1'b0;
      div_sign_q  <= 1'b0;
      div_x_q     <= '0;
      div_y_q     <= '0;
      rem_q       <= 1'b0;
      word_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      div_valid_q <= div_valid_d;
      div_sign_q  <= div_sign_d;
      div_x_q     <= div_x_d;
      div_y_q     <= div_y_d;
      rem_q       <= rem_d;
      word_q      <= word_d;
      result_q    <= result_d;
    end
  end

  // The request pulse is masked by flush so a flush during ISSUE stops the
  // divider from ever seeing the request.
  assign div.div_valid = div_valid_q & ~flush;
  assign div.div_sign  = div_sign_q;
  assign div.div_x     = div_x_q;
  assign div.div_y     = div_y_q;
  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_data      = result_q;

endmodule
